// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability-qualified level FSM, press/release strobes.
// Optional auto-repeat on a held key is compiled in with `define DEBOUNCE_REPEAT_EN.
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam int MAX_SR  = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_SR > REPEAT_PERIOD) ? MAX_SR : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1, sync2;
`ifdef DEBOUNCE_REPEAT_EN
    logic          rep_phase;  // 0: waiting out REPEAT_DELAY, 1: repeating every REPEAT_PERIOD
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            rep_phase     <= 1'b0;
`endif
        end else begin
            sync1         <= btn_raw ^ (ACTIVE_LOW != 0);
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2) begin
                        if (STABLE_CYCLES == 1) begin
                            state       <= HELD;
                            cnt         <= '0;
                            btn_level   <= 1'b1;
                            press_pulse <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                            rep_phase   <= 1'b0;
`endif
                        end else begin
                            state <= PRESS_CHK;
                            cnt   <= CW'(1);
                            busy  <= 1'b1;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!sync2) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        rep_phase   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!sync2) begin
                        if (STABLE_CYCLES == 1) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            btn_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            state <= RELEASE_CHK;
                            cnt   <= CW'(1);
                            busy  <= 1'b1;
                        end
                    end else begin
`ifdef DEBOUNCE_REPEAT_EN
                        if ((!rep_phase && cnt == DELAY_LAST) || (rep_phase && cnt == PERIOD_LAST)) begin
                            press_pulse <= 1'b1;
                            cnt         <= '0;
                            rep_phase   <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
`else
                        cnt <= '0;
`endif
                    end
                end
                RELEASE_CHK: begin
                    if (sync2) begin
                        state     <= HELD;
                        cnt       <= '0;
                        busy      <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
                        rep_phase <= 1'b0;
`endif
                    end else if (cnt == STABLE_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        busy          <= 1'b0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=8, ACTIVE_LOW=0, repeat 20/6.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level, press_pulse, release_pulse, busy;

    int tests = 0;
    int fails = 0;

    button_debouncer #(
        .STABLE_CYCLES(8),
        .ACTIVE_LOW(0),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .busy(busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic rst;
        logic btn;
        logic lvl;
        logic prs;
        logic rel;
        logic bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        chk("pulse_exclusive", int'(press_pulse & release_pulse), 0);
    endtask

    // Edges until the selected pulse is seen (sel 0 = press, 1 = release); bounded.
    task automatic wait_pulse(input int sel, input int bound, output int n);
        n = 0;
        forever begin
            step();
            n++;
            if ((sel == 0 && press_pulse) || (sel == 1 && release_pulse)) break;
            if (n >= bound) begin
                chk(sel == 0 ? "press_timeout" : "release_timeout", n, -1);
                break;
            end
        end
    endtask

    initial begin
        int n;
        // reset, then idle, then a clean press
        for (int i = 0; i < 3; i++)  tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 20; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});   // edge 1
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});   // edge 2
        for (int i = 3; i <= 9; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});   // edge 10: accepted
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            rst     = tbl[i].rst;
            btn_raw = tbl[i].btn;
            step();
            chk($sformatf("vec%0d.level", i),   int'(btn_level),     int'(tbl[i].lvl));
            chk($sformatf("vec%0d.press", i),   int'(press_pulse),   int'(tbl[i].prs));
            chk($sformatf("vec%0d.release", i), int'(release_pulse), int'(tbl[i].rel));
            chk($sformatf("vec%0d.busy", i),    int'(busy),          int'(tbl[i].bsy));
        end

        // aborted release: low 3 cycles then high again
        btn_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_rel.level", int'(btn_level), 1);
            chk("abort_rel.release", int'(release_pulse), 0);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_rel.level", int'(btn_level), 1);
            chk("abort_rel.release", int'(release_pulse), 0);
        end
        chk("abort_rel.busy_after", int'(busy), 0);

        // genuine release
        btn_raw = 1'b0;
        wait_pulse(1, 30, n);
        chk("release.latency", n, 10);
        chk("release.level", int'(btn_level), 0);
        step();
        chk("release.one_cycle", int'(release_pulse), 0);
        for (int i = 0; i < 5; i++) step();

        // bounce on press: 5 high, 2 low, then held high
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin step(); chk("bounce.press", int'(press_pulse), 0); end
        btn_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin step(); chk("bounce.press", int'(press_pulse), 0); end
        btn_raw = 1'b1;
        wait_pulse(0, 30, n);
        chk("bounce.latency", n, 10);
        chk("bounce.level", int'(btn_level), 1);

        // release again, then reset in the middle of press qualification (cnt = 5)
        btn_raw = 1'b0;
        wait_pulse(1, 30, n);
        chk("release2.latency", n, 10);
        for (int i = 0; i < 4; i++) step();
        btn_raw = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("midchk.busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("midchk_rst.level", int'(btn_level), 0);
        chk("midchk_rst.press", int'(press_pulse), 0);
        chk("midchk_rst.release", int'(release_pulse), 0);
        chk("midchk_rst.busy", int'(busy), 0);
        rst = 1'b0;
        wait_pulse(0, 30, n);
        chk("midchk_rst.latency", n, 10);

        // reset while held: no release pulse, key re-qualified
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        chk("held_rst.level", int'(btn_level), 0);
        chk("held_rst.release", int'(release_pulse), 0);
        rst = 1'b0;
        wait_pulse(0, 30, n);
        chk("held_rst.latency", n, 10);

        // keep holding: auto-repeat behaviour
`ifdef DEBOUNCE_REPEAT_EN
        wait_pulse(0, 40, n);
        chk("repeat.first", n, 20);
        wait_pulse(0, 40, n);
        chk("repeat.second", n, 6);
        wait_pulse(0, 40, n);
        chk("repeat.third", n, 6);
`else
        for (int i = 0; i < 40; i++) begin
            step();
            chk("norepeat.press", int'(press_pulse), 0);
        end
        chk("norepeat.level", int'(btn_level), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for push-button inputs. Feeds the step counter and HEX-display path.
- Takes a raw, bouncy, asynchronous key input and synchronises it into the 50 MHz domain.
- Qualifies each level change by requiring it to be stable for a programmable number of cycles.
- Outputs a clean level plus single-cycle press and release pulses. Downstream counters clock-enable on press_pulse rather than clocking on the button itself.

Parameters:
- STABLE_CYCLES, 1000000, consecutive clk cycles a new level must persist before acceptance (20 ms at 50 MHz); legal range >= 1.
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (inverted at input); 0 = raw key reads 1 when pressed.
- REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  input  1  50 MHz system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  raw asynchronous key input.
- btn_level  output  1  debounced level, 1 = pressed.
- press_pulse  output  1  one-cycle strobe on each accepted press (and on each repeat, if enabled).
- release_pulse  output  1  one-cycle strobe on each accepted release.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Input path:
  - btn_raw is XORed with ACTIVE_LOW to give pressed = 1.
  - The result passes through a 2-flop synchroniser (sync1, sync2). The FSM sees only sync2.
- Internal counter:
  - Width is $clog2 of the largest of STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, plus 1.
  - Counter never wraps; it is cleared on every state change.
- FSM states: IDLE, PRESS_CHK, HELD, RELEASE_CHK.
  - IDLE: btn_level = 0. If sync2 = 1, go to PRESS_CHK with cnt = 1.
  - PRESS_CHK:
    - If sync2 = 0, return to IDLE, cnt = 0, no pulse.
    - Else if cnt = STABLE_CYCLES - 1, go to HELD, cnt = 0, press_pulse = 1 for that cycle.
    - Else cnt + 1.
  - HELD: btn_level = 1. If sync2 = 0, go to RELEASE_CHK with cnt = 1.
  - RELEASE_CHK:
    - If sync2 = 1, return to HELD, cnt = 0, no pulse.
    - Else if cnt = STABLE_CYCLES - 1, go to IDLE, release_pulse = 1 for that cycle.
    - Else cnt + 1.
  - STABLE_CYCLES = 1: the CHK states are skipped. Acceptance occurs on the first edge sync2 differs from btn_level.
- Output timing:
  - All outputs are registered.
  - btn_level updates on the same edge the pulse asserts.
  - busy = 1 exactly while in PRESS_CHK or RELEASE_CHK.
- Latency: if btn_raw is first sampled pressed at edge 1 and held, press_pulse and btn_level assert after edge STABLE_CYCLES + 2. Release is symmetric.
- Bounce: any return to the old level during a CHK state aborts qualification. The full count restarts on the next change.
- Pulse exclusivity: press_pulse and release_pulse are never high together. At most one pulse per accepted transition.
- Reset:
  - rst clears sync1, sync2, state (to IDLE), cnt and all outputs to 0. This holds mid-qualification and while HELD.
  - No release_pulse is emitted by reset.
  - A key still pressed when rst deasserts is re-qualified with full latency and produces a press_pulse.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined (auto-repeat enabled):
  - In HELD, cnt counts up from acceptance.
  - At REPEAT_DELAY cycles, press_pulse asserts for one cycle. Thereafter it asserts every REPEAT_PERIOD cycles while HELD.
  - Entering RELEASE_CHK suspends repeat. Returning to HELD from an aborted release restarts the REPEAT_DELAY wait.
- Undefined:
  - Repeat logic is absent; REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - Exactly one press_pulse per press.

Test Plan (STABLE_CYCLES = 8, ACTIVE_LOW = 0):
- Reset with btn_raw = 0 → btn_level, press_pulse, release_pulse, busy all 0; holding 20 cycles keeps them 0.
- btn_raw 0→1 at edge 1, held → busy high from edge 3; press_pulse high for exactly the cycle after edge 10; btn_level = 1 from edge 10; busy low from edge 10.
- Bounce: btn_raw high 5 cycles, low 2, then high held → no pulse during the bounce; a single press_pulse 10 edges after the final rising transition.
- From HELD: btn_raw low for 3 cycles then high → no release_pulse, btn_level stays 1. Then btn_raw low held → release_pulse 10 edges later, btn_level = 0.
- rst asserted for 1 cycle while in PRESS_CHK at cnt = 5, btn_raw still 1 → all outputs 0 after the rst edge. press_pulse asserts 10 edges after rst deasserts.
- With DEBOUNCE_REPEAT_EN, REPEAT_DELAY = 20, REPEAT_PERIOD = 6, btn_raw held → press_pulse at edges 10, 30, 36, 42, … Without the macro, press_pulse at edge 10 only.
